// File: rtl/aclk_load_ctrl.sv
// ---------------------------------------------------------------------------
// aclk_load_ctrl
// Load-port controller for the alarm clock core. Two requesters (keypad,
// time-sync) are arbitrated round-robin. The winning BCD hh:mm value is
// range-checked. If it is legal, it is driven onto the core load port with
// LD_time or LD_alarm for HOLD_CYCLES cycles. Time loads are then confirmed
// by reading the core back. Completion is reported with a one-cycle done
// pulse, the requester index and an error code.
//
// Ports
//   clk, reset              core clock, async active-high reset
//   rq_valid[1:0]           request valid (bit0 keypad, bit1 sync)
//   rq_alarm[1:0]           per-requester target, 1 = alarm, 0 = time
//   rq0_hm, rq1_hm [13:0]   {H1[1:0],H0,M1,M0} request payloads
//   rq_ready[1:0]           one-hot grant pulse (IDLE only)
//   H_in1/H_in0/M_in1/M_in0 digits to the core load port
//   LD_time, LD_alarm       load strobes to the core
//   H_out1/H_out0/M_out1/M_out0  core time readback
//   done, resp_id, err_code completion pulse, requester, 00/01/10 result
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for a request; grant and capture payload
// S_CHECK  | range-check captured digits
// S_DRIVE  | drive digits with one LD strobe for HOLD_CYCLES cycles
// S_VERIFY | compare core readback with captured time, bounded wait
// S_RESP   | done pulse with resp_id / err_code
// ---------------------------------------------------------------------------
module aclk_load_ctrl #(
    parameter int HOLD_CYCLES    = 2,
    parameter int VERIFY_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  rq_valid,
    input  logic [1:0]  rq_alarm,
    input  logic [13:0] rq0_hm,
    input  logic [13:0] rq1_hm,
    output logic [1:0]  rq_ready,
    output logic [1:0]  H_in1,
    output logic [3:0]  H_in0,
    output logic [3:0]  M_in1,
    output logic [3:0]  M_in0,
    output logic        LD_time,
    output logic        LD_alarm,
    input  logic [1:0]  H_out1,
    input  logic [3:0]  H_out0,
    input  logic [3:0]  M_out1,
    input  logic [3:0]  M_out0,
    output logic        done,
    output logic        resp_id,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DRIVE,
        S_VERIFY,
        S_RESP
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
    localparam logic [7:0] VT_LAST   = 8'(VERIFY_TIMEOUT - 1);
    localparam logic [7:0] VT_SAT    = 8'(VERIFY_TIMEOUT);

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_VTO   = 2'b10;

    state_t      state;
    logic        last_grant;
    logic [13:0] cap_hm;
    logic        cap_alarm;
    logic        cap_id;
    logic [3:0]  hold_cnt;
    logic [7:0]  verify_cnt;

    logic        grant_vld;
    logic        grant_id;
    logic        range_ok;
    logic [13:0] readback;

    assign readback = {H_out1, H_out0, M_out1, M_out0};

    // Contention goes to the requester that was not granted last.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (state == S_IDLE) begin
            case (rq_valid)
                2'b01: begin grant_vld = 1'b1; grant_id = 1'b0;        end
                2'b10: begin grant_vld = 1'b1; grant_id = 1'b1;        end
                2'b11: begin grant_vld = 1'b1; grant_id = ~last_grant; end
                default: ;
            endcase
        end
    end

    // The grant must be seen in the same IDLE cycle it is taken, so it is
    // decoded from state; reset forces it low while the FSM sits in IDLE.
    assign rq_ready = (reset || !grant_vld) ? 2'b00 :
                      (grant_id ? 2'b10 : 2'b01);

    assign range_ok = (cap_hm[13:12] <= 2'd2) &&
                      (cap_hm[11:8]  <= 4'd9) &&
                      !((cap_hm[13:12] == 2'd2) && (cap_hm[11:8] > 4'd3)) &&
                      (cap_hm[7:4]   <= 4'd5) &&
                      (cap_hm[3:0]   <= 4'd9);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            cap_hm     <= '0;
            cap_alarm  <= 1'b0;
            cap_id     <= 1'b0;
            hold_cnt   <= '0;
            verify_cnt <= '0;
            H_in1      <= '0;
            H_in0      <= '0;
            M_in1      <= '0;
            M_in0      <= '0;
            LD_time    <= 1'b0;
            LD_alarm   <= 1'b0;
            done       <= 1'b0;
            resp_id    <= 1'b0;
            err_code   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        last_grant <= grant_id;
                        cap_id     <= grant_id;
                        cap_hm     <= grant_id ? rq1_hm : rq0_hm;
                        cap_alarm  <= rq_alarm[grant_id];
                        state      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (range_ok) begin
                        hold_cnt <= HOLD_LOAD;
                        H_in1    <= cap_hm[13:12];
                        H_in0    <= cap_hm[11:8];
                        M_in1    <= cap_hm[7:4];
                        M_in0    <= cap_hm[3:0];
                        LD_time  <= ~cap_alarm;
                        LD_alarm <= cap_alarm;
                        state    <= S_DRIVE;
                    end else begin
                        done     <= 1'b1;
                        resp_id  <= cap_id;
                        err_code <= ERR_RANGE;
                        state    <= S_RESP;
                    end
                end
                S_DRIVE: begin
                    if (hold_cnt == 4'd0) begin
                        H_in1    <= '0;
                        H_in0    <= '0;
                        M_in1    <= '0;
                        M_in0    <= '0;
                        LD_time  <= 1'b0;
                        LD_alarm <= 1'b0;
                        if (cap_alarm) begin
                            done     <= 1'b1;
                            resp_id  <= cap_id;
                            err_code <= ERR_OK;
                            state    <= S_RESP;
                        end else begin
                            verify_cnt <= '0;
                            state      <= S_VERIFY;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                S_VERIFY: begin
                    if (readback == cap_hm) begin
                        done     <= 1'b1;
                        resp_id  <= cap_id;
                        err_code <= ERR_OK;
                        state    <= S_RESP;
                    end else if (verify_cnt >= VT_LAST) begin
                        done     <= 1'b1;
                        resp_id  <= cap_id;
                        err_code <= ERR_VTO;
                        state    <= S_RESP;
                    end else if (verify_cnt != VT_SAT) begin
                        verify_cnt <= verify_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aclk_load_ctrl.sv
module tb_aclk_load_ctrl;

    localparam int HOLD = 2;
    localparam int VT   = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rq_valid;
    logic [1:0]  rq_alarm;
    logic [13:0] rq0_hm, rq1_hm;
    logic [1:0]  rq_ready;
    logic [1:0]  H_in1;
    logic [3:0]  H_in0, M_in1, M_in0;
    logic        LD_time, LD_alarm;
    logic [1:0]  H_out1;
    logic [3:0]  H_out0, M_out1, M_out0;
    logic        done, resp_id;
    logic [1:0]  err_code;

    aclk_load_ctrl #(.HOLD_CYCLES(HOLD), .VERIFY_TIMEOUT(VT)) dut (
        .clk(clk), .reset(reset),
        .rq_valid(rq_valid), .rq_alarm(rq_alarm),
        .rq0_hm(rq0_hm), .rq1_hm(rq1_hm), .rq_ready(rq_ready),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm),
        .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
        .done(done), .resp_id(resp_id), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: either latches whatever is time-loaded, or is held at a
    // forced value.
    logic [13:0] core_val;
    logic        core_echo, core_force;
    logic [13:0] core_force_val;
    always @(posedge clk) begin
        if (core_force) core_val <= core_force_val;
        else if (core_echo && LD_time) core_val <= {H_in1, H_in0, M_in1, M_in0};
    end
    assign {H_out1, H_out0, M_out1, M_out0} = core_val;

    int n_checks = 0;
    int n_pass   = 0;

    // Observations of one request
    int o_to, o_t, o_ready, o_ldt, o_lda, o_first, o_bad, o_done, o_id, o_err, o_rdy_extra;

    function automatic logic [13:0] bcd(input int h1, input int h0, input int m1, input int m0);
        logic [1:0] a; logic [3:0] b, c, d;
        a = h1[1:0]; b = h0[3:0]; c = m1[3:0]; d = m0[3:0];
        return {a, b, c, d};
    endfunction

    // A legal value is a real clock time 00:00..23:59 with decimal digits.
    function automatic bit legal_hm(input logic [13:0] v);
        int h1 = int'(v[13:12]); int h0 = int'(v[11:8]);
        int m1 = int'(v[7:4]);   int m0 = int'(v[3:0]);
        return (h0 <= 9) && (m0 <= 9) && (h1 * 10 + h0 <= 23) && (m1 * 10 + m0 <= 59);
    endfunction

    function automatic int exp_err(input bit legal, input bit alarm, input bit match);
        if (!legal) return 1;
        if (alarm || match) return 0;
        return 2;
    endfunction

    function automatic int exp_done(input int err, input bit alarm);
        if (err == 1) return 2;
        if (err == 2) return 2 + HOLD + VT;
        return alarm ? 2 + HOLD : 3 + HOLD;
    endfunction

    // Drives one single-requester transaction and records what happened.
    // Called at a negedge; returns at the negedge after the done cycle.
    task automatic do_request(input int id, input logic alarm, input logic [13:0] hm);
        bit got = 0;
        o_to = 0; o_t = -1; o_ready = 0; o_ldt = 0; o_lda = 0; o_first = -1;
        o_bad = 0; o_done = -1; o_id = -1; o_err = -1; o_rdy_extra = 0;
        if (id == 0) rq0_hm = hm; else rq1_hm = hm;
        rq_alarm[id] = alarm;
        rq_valid = (id == 0) ? 2'b01 : 2'b10;
        for (int k = 0; k < 5 && !got; k++) begin
            #1;
            if (rq_ready != 2'b00) begin got = 1; o_t = cyc; o_ready = int'(rq_ready); end
            else @(negedge clk);
        end
        @(negedge clk);
        rq_valid = 2'b00;
        if (!got) begin o_to = 1; return; end
        for (int k = 0; k < 40; k++) begin
            #1;
            if (rq_ready != 2'b00) o_rdy_extra++;
            if (LD_time || LD_alarm) begin
                if (o_first < 0) o_first = cyc - o_t;
                if ({H_in1, H_in0, M_in1, M_in0} !== hm) o_bad++;
                if (LD_time && LD_alarm) o_bad++;
                if (LD_time) o_ldt++;
                if (LD_alarm) o_lda++;
            end else if ({H_in1, H_in0, M_in1, M_in0} !== 14'd0) begin
                o_bad++;
            end
            if (done) begin
                o_done = cyc - o_t; o_id = int'(resp_id); o_err = int'(err_code);
                break;
            end
            @(negedge clk);
        end
        if (o_done < 0) o_to = 1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rq_valid = 2'b11; rq_alarm = 2'b00; rq0_hm = bcd(1, 2, 3, 4); rq1_hm = bcd(1, 2, 3, 4);
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (rq_ready !== 2'b00) $display("FAIL reset_ready: got %b want 00", rq_ready);
        else n_pass++;
        n_checks++;
        if ({LD_time, LD_alarm, H_in1, H_in0, M_in1, M_in0, done, resp_id, err_code} !== '0)
            $display("FAIL reset_outputs: got %b want all 0",
                     {LD_time, LD_alarm, H_in1, H_in0, M_in1, M_in0, done, resp_id, err_code});
        else n_pass++;
        rq_valid = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_first_load;
        core_force = 1'b0; core_echo = 1'b1;
        do_request(0, 1'b0, bcd(1, 2, 3, 4));
        n_checks++; if (o_to !== 0) $display("FAIL first_timeout: got %0d want 0", o_to); else n_pass++;
        n_checks++; if (o_ready !== 1) $display("FAIL first_ready: got %0d want 1", o_ready); else n_pass++;
        n_checks++; if (o_first !== 2) $display("FAIL first_ld_start: got %0d want 2", o_first); else n_pass++;
        n_checks++; if (o_ldt !== HOLD || o_lda !== 0) $display("FAIL first_ld_len: got t=%0d a=%0d want t=%0d a=0", o_ldt, o_lda, HOLD); else n_pass++;
        n_checks++; if (o_bad !== 0) $display("FAIL first_digits: got %0d bad cycles want 0", o_bad); else n_pass++;
        n_checks++; if (o_done !== 5) $display("FAIL first_done: got T+%0d want T+5", o_done); else n_pass++;
        n_checks++; if (o_id !== 0 || o_err !== 0) $display("FAIL first_resp: got id=%0d err=%0d want 0/0", o_id, o_err); else n_pass++;
    endtask

    task automatic test_range;
        logic [13:0] bad_v[2];
        logic [13:0] ok_v[2];
        bad_v[0] = bcd(2, 4, 0, 0); bad_v[1] = bcd(0, 9, 6, 0);
        ok_v[0]  = bcd(2, 3, 5, 9); ok_v[1]  = bcd(0, 0, 0, 0);
        core_force = 1'b0; core_echo = 1'b1;
        for (int i = 0; i < 2; i++) begin
            do_request(1, 1'b0, bad_v[i]);
            n_checks++; if (o_ldt + o_lda !== 0) $display("FAIL range_no_ld[%0d]: got %0d strobes want 0", i, o_ldt + o_lda); else n_pass++;
            n_checks++; if (o_done !== 2) $display("FAIL range_done[%0d]: got T+%0d want T+2", i, o_done); else n_pass++;
            n_checks++; if (o_id !== 1 || o_err !== 1) $display("FAIL range_resp[%0d]: got id=%0d err=%0d want 1/1", i, o_id, o_err); else n_pass++;
        end
        for (int i = 0; i < 2; i++) begin
            do_request(1, 1'b0, ok_v[i]);
            n_checks++; if (o_ldt !== HOLD) $display("FAIL range_edge_ld[%0d]: got %0d want %0d", i, o_ldt, HOLD); else n_pass++;
            n_checks++; if (o_done !== 3 + HOLD || o_err !== 0) $display("FAIL range_edge_resp[%0d]: got T+%0d err=%0d want T+%0d err=0", i, o_done, o_err, 3 + HOLD); else n_pass++;
        end
    endtask

    task automatic test_alarm;
        core_force = 1'b0; core_echo = 1'b1;
        do_request(0, 1'b1, bcd(0, 6, 3, 0));
        n_checks++; if (o_lda !== HOLD || o_ldt !== 0) $display("FAIL alarm_ld: got a=%0d t=%0d want a=%0d t=0", o_lda, o_ldt, HOLD); else n_pass++;
        n_checks++; if (o_bad !== 0) $display("FAIL alarm_digits: got %0d bad cycles want 0", o_bad); else n_pass++;
        n_checks++; if (o_done !== 2 + HOLD || o_err !== 0) $display("FAIL alarm_done: got T+%0d err=%0d want T+%0d err=0", o_done, o_err, 2 + HOLD); else n_pass++;
    endtask

    task automatic test_timeout;
        core_echo = 1'b0; core_force = 1'b1; core_force_val = bcd(0, 0, 0, 0);
        do_request(0, 1'b0, bcd(0, 7, 1, 5));
        n_checks++; if (o_ldt !== HOLD) $display("FAIL timeout_ld: got %0d want %0d", o_ldt, HOLD); else n_pass++;
        n_checks++; if (o_done !== 2 + HOLD + VT) $display("FAIL timeout_done: got T+%0d want T+%0d", o_done, 2 + HOLD + VT); else n_pass++;
        n_checks++; if (o_err !== 2 || o_id !== 0) $display("FAIL timeout_resp: got err=%0d id=%0d want 2/0", o_err, o_id); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int gid[3];
        int gcyc[3];
        int dcyc[3];
        int ng = 0, nd = 0, nrdy = 0, nonhot = 0;
        for (int j = 0; j < 3; j++) begin gid[j] = -1; gcyc[j] = -100; dcyc[j] = -200; end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rq0_hm = bcd(0, 1, 0, 0); rq1_hm = bcd(0, 2, 0, 0);
        rq_alarm = 2'b11; rq_valid = 2'b11;
        for (int k = 0; k < 40 && nd < 3; k++) begin
            #1;
            if (rq_ready != 2'b00) begin
                nrdy++;
                if (rq_ready != 2'b01 && rq_ready != 2'b10) nonhot++;
                if (ng < 3) begin gid[ng] = (rq_ready == 2'b10) ? 1 : 0; gcyc[ng] = cyc; ng++; end
            end
            if (done) begin if (nd < 3) dcyc[nd] = cyc; nd++; end
            @(negedge clk);
        end
        rq_valid = 2'b00; rq_alarm = 2'b00;
        n_checks++; if (nd !== 3) $display("FAIL b2b_dones: got %0d want 3", nd); else n_pass++;
        n_checks++; if (nrdy !== 3 || nonhot !== 0) $display("FAIL b2b_ready_cycles: got %0d (non-onehot %0d) want 3", nrdy, nonhot); else n_pass++;
        n_checks++; if (gid[0] !== 0 || gid[1] !== 1 || gid[2] !== 0) $display("FAIL b2b_order: got %0d,%0d,%0d want 0,1,0", gid[0], gid[1], gid[2]); else n_pass++;
        for (int j = 0; j < 2; j++) begin
            n_checks++;
            if (gcyc[j + 1] - dcyc[j] !== 1) $display("FAIL b2b_gap[%0d]: got %0d want 1", j, gcyc[j + 1] - dcyc[j]);
            else n_pass++;
        end
        n_checks++; if (dcyc[0] - gcyc[0] !== 2 + HOLD) $display("FAIL b2b_latency: got %0d want %0d", dcyc[0] - gcyc[0], 2 + HOLD); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_drive;
        int t = -1;
        int g = 0;
        int ndone = 0;
        bit seen = 0;
        int rid = -1;
        core_force = 1'b0; core_echo = 1'b1;
        rq0_hm = bcd(0, 5, 0, 5); rq_alarm = 2'b00; rq_valid = 2'b01;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (rq_ready == 2'b01) begin t = cyc; break; end
            @(negedge clk);
        end
        @(negedge clk);
        rq_valid = 2'b00;
        n_checks++; if (t < 0) $display("FAIL abort_grant: no grant within 5 cycles, want grant"); else n_pass++;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (LD_time !== 1'b1) $display("FAIL abort_pre_ld: got %b want 1", LD_time); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({LD_time, LD_alarm, H_in1, H_in0, M_in1, M_in0, done} !== '0)
            $display("FAIL abort_async_drop: got %b want all 0", {LD_time, LD_alarm, H_in1, H_in0, M_in1, M_in0, done});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) begin
            #1;
            if (done) ndone++;
            @(negedge clk);
        end
        n_checks++; if (ndone !== 0) $display("FAIL abort_no_done: got %0d pulses want 0", ndone); else n_pass++;
        rq0_hm = bcd(1, 1, 1, 1); rq1_hm = bcd(2, 2, 2, 2); rq_alarm = 2'b11; rq_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (rq_ready != 2'b00) begin g = int'(rq_ready); break; end
            @(negedge clk);
        end
        @(negedge clk);
        rq_valid = 2'b00;
        n_checks++; if (g !== 1) $display("FAIL abort_contention: got ready=%0d want 1", g); else n_pass++;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (done) begin seen = 1; rid = int'(resp_id); break; end
            @(negedge clk);
        end
        n_checks++; if (!seen || rid !== 0) $display("FAIL abort_next_done: got seen=%0d id=%0d want 1/0", seen, rid); else n_pass++;
        rq_alarm = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++) begin
            int id = int'($urandom_range(0, 1));
            bit alarm = ($urandom_range(0, 3) == 0);
            int mode = int'($urandom_range(0, 2));
            logic [13:0] hm;
            bit lg, match;
            int e_err, e_done;
            if ($urandom_range(0, 2) != 0) begin
                int h = int'($urandom_range(0, 23));
                int m = int'($urandom_range(0, 59));
                hm = bcd(h / 10, h % 10, m / 10, m % 10);
            end else begin
                hm = 14'($urandom);
            end
            if (mode == 0) begin
                core_force = 1'b0; core_echo = 1'b1; match = 1;
            end else if (mode == 1) begin
                core_echo = 1'b0; core_force = 1'b1; core_force_val = hm; match = 1;
            end else begin
                core_echo = 1'b0; core_force = 1'b1; core_force_val = 14'($urandom);
                match = (core_force_val == hm);
            end
            lg = legal_hm(hm);
            e_err = exp_err(lg, alarm, match);
            e_done = exp_done(e_err, alarm);
            do_request(id, alarm, hm);
            n_checks++; if (o_ready !== (id == 0 ? 1 : 2)) $display("FAIL rnd_ready[%0d]: got %0d want %0d", i, o_ready, id == 0 ? 1 : 2); else n_pass++;
            n_checks++; if (o_ldt !== ((lg && !alarm) ? HOLD : 0) || o_lda !== ((lg && alarm) ? HOLD : 0))
                $display("FAIL rnd_ld[%0d]: got t=%0d a=%0d hm=%h", i, o_ldt, o_lda, hm); else n_pass++;
            n_checks++; if (o_bad !== 0 || o_rdy_extra !== 0) $display("FAIL rnd_outputs[%0d]: got bad=%0d extra_ready=%0d want 0/0", i, o_bad, o_rdy_extra); else n_pass++;
            n_checks++; if (o_done !== e_done) $display("FAIL rnd_done[%0d]: got T+%0d want T+%0d hm=%h", i, o_done, e_done, hm); else n_pass++;
            n_checks++; if (o_err !== e_err || o_id !== id) $display("FAIL rnd_resp[%0d]: got err=%0d id=%0d want err=%0d id=%0d", i, o_err, o_id, e_err, id); else n_pass++;
        end
        core_force = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        rq_valid = 2'b00; rq_alarm = 2'b00; rq0_hm = '0; rq1_hm = '0;
        core_echo = 1'b0; core_force = 1'b1; core_force_val = '0;
        test_reset();
        test_first_load();
        test_range();
        test_alarm();
        test_timeout();
        test_back_to_back();
        test_reset_mid_drive();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aclk_load_ctrl.md
# aclk_load_ctrl

Load-port controller for the alarm clock core. Arbitrates round-robin between two configuration requesters (keypad, time-sync), range-checks each BCD hour/minute request, and drives H_in1/H_in0/M_in1/M_in0 with LD_time or LD_alarm for a programmable hold period. For time loads it then reads back H_out/M_out to confirm the load, and it reports done/error per request. It sits between the requesters and the alarm clock core's load inputs, on the core's clock.

## Interface
- HOLD_CYCLES, 2: cycles LD_time/LD_alarm stay asserted (legal range 1..15)
- VERIFY_TIMEOUT, 8: max readback cycles after a time load before error (legal range 1..255)

- clk  in  1  core clock; all logic on posedge
- reset  in  1  asynchronous, active-high
- rq_valid  in  2  per-requester request valid; bit 0 = keypad, bit 1 = sync
- rq_alarm  in  2  per-requester target: 1 = alarm, 0 = time
- rq0_hm, rq1_hm  in  14 each  packed {H1[1:0],H0[3:0],M1[3:0],M0[3:0]}
- rq_ready  out  2  one-hot grant/accept pulse
- H_in1  out  2  hour MSB to core
- H_in0, M_in1, M_in0  out  4 each  hour LSB, minute MSB/LSB to core
- LD_time, LD_alarm  out  1 each  load strobes to core
- H_out1  in  2  core hour MSB readback
- H_out0, M_out1, M_out0  in  4 each  core hour LSB, minute MSB/LSB readback
- done  out  1  one-cycle completion pulse
- resp_id  out  1  requester index of the completed request; valid with done
- err_code  out  2  00 ok, 01 range error, 10 verify timeout; valid with done

## Operation
- FSM states and transitions:
  - IDLE: if any rq_valid, grant, then go to CHECK.
  - CHECK: range-check the captured value. Pass: go to DRIVE. Fail: latch err 01, go to RESP.
  - DRIVE: hold for HOLD_CYCLES cycles. Alarm target: go to RESP with err 00. Time target: go to VERIFY.
  - VERIFY: match: latch err 00, go to RESP. VERIFY_TIMEOUT cycles with no match: latch err 10, go to RESP.
  - RESP: pulse done, go to IDLE.
- Arbitration:
  - Round-robin with a last-grant pointer, reset value 1, so requester 0 wins the first contention.
  - A single requester is granted regardless of the pointer.
  - The pointer updates only on grant.
- Handshake:
  - In IDLE, rq_ready[i] is high for exactly one cycle for the chosen i.
  - The payload (rq_hm, rq_alarm) is captured on that edge.
  - Requesters hold valid and payload stable until ready.
  - Only one request is in flight; rq_ready stays 0 outside IDLE.
- Range check, all on unsigned fields. Any violation gives err 01, and no LD strobe is issued.
  - H1 ≤ 2
  - H0 ≤ 9
  - if H1 == 2 then H0 ≤ 3
  - M1 ≤ 5
  - M0 ≤ 9
- DRIVE:
  - H_in*/M_in* carry the captured digits.
  - Exactly one of LD_time/LD_alarm is high, for every DRIVE cycle.
  - Outside DRIVE, all load outputs are 0.
- VERIFY: compares {H_out1,H_out0,M_out1,M_out0} with the captured value each cycle; seconds are ignored.
- Outputs in RESP:
  - done = 1.
  - resp_id = captured index.
  - err_code = latched result.
  - resp_id/err_code hold their values until the next RESP.

## Timing
- Reset:
  - Asynchronous; all outputs go to 0 immediately.
  - FSM goes to IDLE, counters clear, RR pointer = 1.
  - Reset mid-DRIVE drops LD_* in the same instant.
  - An aborted request produces no done.
- Latency, with grant (rq_ready high) in cycle T:
  - CHECK runs in T+1.
  - DRIVE runs in T+2 .. T+1+HOLD_CYCLES.
  - Alarm load: done in T+2+HOLD_CYCLES.
  - Time load matching on the first VERIFY cycle: done in T+3+HOLD_CYCLES.
  - Time load that times out: done in T+2+HOLD_CYCLES+VERIFY_TIMEOUT.
  - Range error: done in T+2.
- Back-to-back requests:
  - The earliest next grant is the cycle after RESP.
  - A requester re-raising valid during RESP is not granted until IDLE.
- Simultaneous valids in IDLE: the RR pointer decides, then it alternates.
- Deassertion of valid before ready is a protocol violation; behaviour is undefined and not checked.
- VERIFY counter is 8-bit and saturates at VERIFY_TIMEOUT.
- Hold counter is 4-bit.

## Test plan
- Reset, then rq_valid=01, rq_alarm=0, rq0_hm=12:34, core echoes the value. Required:
  - rq_ready=01 at T.
  - LD_time high T+2..T+3 with H_in1=1, H_in0=2, M_in1=3, M_in0=4.
  - done at T+5 with resp_id=0, err=00.
- rq_valid=11 held for three requests. Required: grants in order 0, 1, 0; the next request is not granted before its IDLE cycle.
- Range errors: rq1_hm=24:00 and rq1_hm=09:60. Required:
  - No LD strobe for either.
  - done at T+2 with resp_id=1, err=01.
  - Requests 23:59 and 00:00 are accepted.
- Alarm load 06:30. Required:
  - LD_alarm high for HOLD_CYCLES cycles, LD_time stays 0.
  - No VERIFY phase; done at T+4 with err 00.
- Time load 07:15 with the core held at 00:00. Required: done at T+4+VERIFY_TIMEOUT (T+12 with defaults) with err 10.
- Assert reset during the second DRIVE cycle. Required:
  - LD_time and the H_in/M_in outputs drop to 0 asynchronously.
  - No done pulse.
  - The next request is granted normally, with requester 0 winning contention.
